// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single regfile write port among NREQ
// writeback requesters using round-robin arbitration with ready/valid
// handshakes. The winning write goes into a one-entry registered output
// stage that drives rf_we/rf_rW/rf_din. A two-port lookup lets the read
// stage bypass a write that is still sitting in that stage.
//
// Optional feature macro: WB_ARB_PRIO0_EN
//   defined   - requester 0 has fixed top priority; 1..NREQ-1 round-robin
//   undefined - pure round-robin over all NREQ requesters
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   freeze            blocks new grants while high
//   req_valid/rd/data per-requester write requests (packed, requester i at slice i)
//   req_ready         one-hot grant (combinational)
//   rf_we/rW/din      registered regfile write port
//   lk_rA/rB          lookup indices; lk_hit*/lk_data* combinational bypass
//   conflict_cnt      saturating count of cycles with an unserved valid requester
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [5*NREQ-1:0]     req_rd,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_rW,
  output logic [WIDTH-1:0]      rf_din,
  input  logic [4:0]            lk_rA,
  input  logic [4:0]            lk_rB,
  output logic                  lk_hitA,
  output logic                  lk_hitB,
  output logic [WIDTH-1:0]      lk_dataA,
  output logic [WIDTH-1:0]      lk_dataB,
  output logic [15:0]           conflict_cnt
);

  localparam int unsigned PW      = $clog2(NREQ);
  localparam int unsigned CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // State
  logic [PW-1:0]    ptr_q,    ptr_d;
  logic             rf_we_q,  rf_we_d;
  logic [4:0]       rf_rW_q,  rf_rW_d;
  logic [WIDTH-1:0] rf_din_q, rf_din_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Arbitration results
  logic             gnt_found;
  logic [PW-1:0]    gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic [PW:0]      scan_idx;
  logic [PW:0]      ptr_inc;
  logic [4:0]       sel_rd;
  logic [WIDTH-1:0] sel_data;
  logic             conflict;

  // Grant selection: first valid requester scanning upward from the pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    gnt       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NREQ)) begin
        scan_idx = scan_idx - (PW+1)'(NREQ);
      end
`ifdef WB_ARB_PRIO0_EN
      // Requester 0 is handled by the fixed-priority override below
      if (!gnt_found && req_valid[scan_idx[PW-1:0]] && (scan_idx != '0)) begin
`else
      if (!gnt_found && req_valid[scan_idx[PW-1:0]]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[PW-1:0];
      end
    end
`ifdef WB_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
    if (freeze || rst) begin
      gnt_found = 1'b0;
    end
    if (gnt_found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = gnt;

  // Winner's payload mux
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // A cycle is a conflict when more requesters are valid than get served
  assign conflict = !freeze &&
                    ($countones(req_valid) > (gnt_found ? 1 : 0));

  // Next-state logic
  always_comb begin
    ptr_d    = ptr_q;
    rf_we_d  = 1'b0;
    rf_rW_d  = rf_rW_q;
    rf_din_d = rf_din_q;
    cnt_d    = cnt_q;
    ptr_inc  = {1'b0, gnt_idx} + (PW+1)'(1);

    if (gnt_found) begin
`ifdef WB_ARB_PRIO0_EN
      // Fixed-priority grants to requester 0 leave the rotation untouched
      if (gnt_idx != '0) begin
        ptr_d = (ptr_inc == (PW+1)'(NREQ)) ? '0 : ptr_inc[PW-1:0];
      end
`else
      ptr_d = (ptr_inc == (PW+1)'(NREQ)) ? '0 : ptr_inc[PW-1:0];
`endif
      // Writes to x0 handshake normally but never reach the regfile
      rf_we_d  = (sel_rd != 5'd0);
      rf_rW_d  = sel_rd;
      rf_din_d = sel_data;
    end

    if (conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      rf_we_q  <= 1'b0;
      rf_rW_q  <= '0;
      rf_din_q <= '0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rf_we_q  <= rf_we_d;
      rf_rW_q  <= rf_rW_d;
      rf_din_q <= rf_din_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_rW        = rf_rW_q;
  assign rf_din       = rf_din_q;
  assign conflict_cnt = cnt_q;

  // Bypass lookup against the pending write; x0 never hits
  assign lk_hitA  = rf_we_q && (rf_rW_q == lk_rA) && (lk_rA != 5'd0);
  assign lk_hitB  = rf_we_q && (rf_rW_q == lk_rB) && (lk_rB != 5'd0);
  assign lk_dataA = lk_hitA ? rf_din_q : '0;
  assign lk_dataB = lk_hitB ? rf_din_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter (default build): directed steps followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  freeze;
  logic [NREQ-1:0]       req_valid;
  logic [5*NREQ-1:0]     req_rd;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rf_we;
  logic [4:0]            rf_rW;
  logic [WIDTH-1:0]      rf_din;
  logic [4:0]            lk_rA, lk_rB;
  logic                  lk_hitA, lk_hitB;
  logic [WIDTH-1:0]      lk_dataA, lk_dataB;
  logic [15:0]           conflict_cnt;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_rW(rf_rW), .rf_din(rf_din),
    .lk_rA(lk_rA), .lk_rB(lk_rB),
    .lk_hitA(lk_hitA), .lk_hitB(lk_hitB),
    .lk_dataA(lk_dataA), .lk_dataB(lk_dataB),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: next requester in turn, pending write, conflict count
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rW;
  logic [31:0] m_din;
  int          m_cnt;

  logic [4:0]  rd_a  [NREQ];
  logic [31:0] dat_a [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_rW = '0; m_din = '0; m_cnt = 0;
  endtask

  // Whoever is valid and comes first in turn order, or -1
  function automatic int exp_grant();
    if (freeze) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Check all outputs for the current inputs, then advance one clock
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_ready;
    logic hA, hB;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[5*i +: 5]         = rd_a[i];
      req_data[WIDTH*i +: WIDTH] = dat_a[i];
    end
    #1;
    g = exp_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    hA = m_we && (m_rW == lk_rA) && (lk_rA != 0);
    hB = m_we && (m_rW == lk_rB) && (lk_rB != 0);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_rW", 64'(rf_rW), 64'(m_rW));
      chk("rf_din", 64'(rf_din), 64'(m_din));
    end
    chk("lk_hitA", 64'(lk_hitA), 64'(hA));
    chk("lk_hitB", 64'(lk_hitB), 64'(hB));
    chk("lk_dataA", 64'(lk_dataA), hA ? 64'(m_din) : 64'd0);
    chk("lk_dataB", 64'(lk_dataB), hB ? 64'(m_din) : 64'd0);
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    @(posedge clk);
    if (!freeze && ($countones(req_valid) > ((g >= 0) ? 1 : 0)) && m_cnt < 65535)
      m_cnt++;
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      m_we  = (rd_a[g] != 0);
      m_rW  = rd_a[g];
      m_din = dat_a[g];
    end else begin
      m_we = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; req_valid = '1; req_rd = '0; req_data = '0;
    lk_rA = '0; lk_rB = '0;
    for (int i = 0; i < NREQ; i++) begin rd_a[i] = '0; dat_a[i] = '0; end
    model_reset();

    // Reset holds everything quiet even with all requesters valid
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    rst = 1'b0;

    // Fairness: all valid for 6 cycles, distinct destinations
    for (int i = 0; i < NREQ; i++) begin rd_a[i] = 5'(10 + i); dat_a[i] = 32'h1000 + i; end
    for (int c = 0; c < 6; c++) begin
      lk_rA = 5'(10 + ((c + 2) % 3));
      tick();
    end
    chk("fair_cnt", 64'(conflict_cnt), 64'd6);

    // Single write plus bypass of it
    req_valid = 3'b001; rd_a[0] = 5'd5; dat_a[0] = 32'hDEADBEEF;
    tick();
    req_valid = '0; lk_rA = 5'd5; lk_rB = 5'd6;
    tick();

    // Write to x0 handshakes but is suppressed
    req_valid = 3'b010; rd_a[1] = 5'd0; dat_a[1] = 32'hCAFEF00D;
    tick();
    req_valid = '0; lk_rA = 5'd0; lk_rB = 5'd0;
    tick();

    // Freeze blocks grants and conflict counting
    freeze = 1'b1; req_valid = 3'b100; rd_a[2] = 5'd9; dat_a[2] = 32'h12345678;
    for (int c = 0; c < 4; c++) tick();
    freeze = 1'b0;
    tick();
    req_valid = '0; lk_rA = 5'd9;
    tick();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      freeze    = (($urandom % 8) == 0);
      for (int i = 0; i < NREQ; i++) begin
        rd_a[i]  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        dat_a[i] = $urandom;
      end
      lk_rA = ($urandom % 2) ? m_rW : 5'($urandom);
      lk_rB = ($urandom % 4) == 0 ? 5'd0 : (($urandom % 2) ? m_rW : 5'($urandom));
      tick();
    end

    // Asynchronous reset while a write is pending
    freeze = 1'b0; req_valid = 3'b001; rd_a[0] = 5'd7; dat_a[0] = 32'hA5A5A5A5;
    lk_rA = 5'd7;
    tick();
    req_valid = '0;
    tick();
    req_valid = 3'b011; rd_a[1] = 5'd8;
    tick();
    #1;
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_we", 64'(rf_we), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    chk("async_rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("async_rst_hitA", 64'(lk_hitA), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = 3'b110;
    tick();
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
